// File: rtl/sobel_window_reader.sv
// 3x3 window former for a Sobel filter: shifts line-buffer taps into a register
// array and flags complete interior windows while tracking raster position.
module sobel_window_reader #(
  parameter int unsigned IMG_WIDTH  = 128,
  parameter int unsigned IMG_HEIGHT = 128
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        InValid,
  input  logic [7:0]  DataIn,
  input  logic [7:0]  Tap1,
  input  logic [7:0]  Tap2,
  output logic        Enable,
  output logic [71:0] Window,
  output logic        WinValid,
  output logic        FrameDone
);

  localparam int unsigned PIX_W = 8;
  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e                            state_q, state_d;
  logic [COL_W-1:0]                  col_q, col_d;
  logic [ROW_W-1:0]                  row_q, row_d;
  logic [2:0][2:0][PIX_W-1:0]        win_q, win_d;
  logic                              win_valid_q, win_valid_d;
  logic                              frame_done_q, frame_done_d;
  logic                              last_col;
  logic                              last_row;

  // Line buffers must shift on every accepted pixel, independent of state/reset.
  assign Enable    = InValid;
  assign Window    = win_q;
  assign WinValid  = win_valid_q;
  assign FrameDone = frame_done_q;

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  // Next-state: window shift, raster counters, FSM and output flags.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (InValid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = Tap2;
      win_d[1][2] = Tap1;
      win_d[2][2] = DataIn;

      // Columns 0/1 would mix pixels from the previous row, so they never qualify.
      win_valid_d  = (32'(row_q) >= 32'd2) && (32'(col_q) >= 32'd2);
      frame_done_d = last_col && last_row;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (last_col && (row_q == ROW_W'(1))) state_d = STREAM;
        STREAM:  if (last_col && last_row) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
